alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage of the ALU, directly downstream of the shifter and the arithmetic/logic unit.
- Selects the combinational result by the 6-bit funct Signal and registers it with a valid pulse.
- Contains a 32-cycle sequential shift-add MULTU multiplier and the HI/LO registers, readable via MFHI/MFLO.
- Enforces a ready/valid handshake toward the control unit.

Parameters:
WIDTH, 32, datapath width; HI and LO are WIDTH bits each, product is 2*WIDTH.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Signal  input  6  funct code of the operation
op_valid  input  1  operation present this cycle
op_ready  output  1  stage can accept; equals !busy
dataA  input  32  operand A (multiplicand for MULTU)
dataB  input  32  operand B (multiplier for MULTU)
alu_data  input  32  combinational ADD/SUB/AND/OR/SLT result
shift_data  input  32  combinational shifter (SRL) result
dataOut  output  32  registered result
result_valid  output  1  one-cycle pulse: dataOut updated
mult_done  output  1  one-cycle pulse: HI/LO written by MULTU
busy  output  1  multiply in progress

Behaviour:
- Funct codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SRL 000010, MULTU 011001, MFHI 010000, MFLO 010010.
- Reset (reset=0, asynchronous): dataOut=0, HI=0, LO=0, result_valid=0, mult_done=0, busy=0, counter=0, product register=0. Asserting reset mid-multiply aborts the multiply; HI/LO stay 0.
- Accept: an op is taken at a rising edge when op_valid=1 and op_ready=1. While busy=1, op_valid is ignored. Upstream holds Signal and operands until accepted.
- ADD/SUB/AND/OR/SLT accepted at edge E: dataOut<=alu_data, result_valid=1 for the cycle after E.
- SRL accepted: dataOut<=shift_data, same 1-cycle latency.
- MFHI/MFLO accepted: dataOut<=HI/LO, same 1-cycle latency. If the op arrives during a multiply it stalls (not ready) and so reads the final HI/LO.
- Undefined Signal accepted: dataOut<=0, result_valid pulses (matches shifter zero-default).
- result_valid is 0 in every cycle not following an accept. dataOut holds its value otherwise.
- MULTU state machine, states IDLE and MUL:
  - IDLE to MUL on accepted MULTU at edge E0: P[63:32]=0, P[31:0]=dataB, M=dataA, counter=0, busy=1.
  - MUL, each edge E1..E32: sum[32:0] = {1'b0,P[63:32]} + (P[0] ? {1'b0,M} : 0); P <= {sum, P[31:1]}; counter++.
  - 33-bit sum, so the carry is never lost.
  - At E32 (counter reaches WIDTH): HI<=P_next[63:32], LO<=P_next[31:0], busy<=0, state IDLE, mult_done=1 for one cycle.
  - op_ready is low for exactly 32 cycles. The earliest next accept is edge E33.
- MULTU produces no result_valid and leaves dataOut unchanged.
- A MULTU accepted back-to-back after completion restarts cleanly and overwrites HI/LO at its own completion.
- All arithmetic is unsigned; no overflow flags.

Test Plan:
- Reset: reset=0 mid-run → all outputs 0 immediately, asynchronously.
- ADD: op_valid=1, Signal=100000, alu_data=0x00001234 → next cycle dataOut=0x00001234, result_valid=1 for exactly one cycle.
- SRL: Signal=000010, shift_data=0x0F000000 → dataOut=0x0F000000 after 1 cycle. Undefined Signal=111111 → dataOut=0, result_valid=1.
- MULTU: dataA=0xFFFFFFFF, dataB=0xFFFFFFFF → busy high 32 cycles, mult_done at cycle 32. Then MFHI → 0xFFFFFFFE and MFLO → 0x00000001. Repeat with 7×6 → HI=0, LO=42.
- Stall: MFLO asserted 5 cycles after a MULTU of 3×5 → op_ready=0 until completion. MFLO accepted at E33 → dataOut=15.
- Reset mid-multiply: reset=0 at cycle 10 of a MULTU, then released → busy=0, op_ready=1, HI=LO=0. A new ADD is accepted on the next edge.

Source files
------------

// File: rtl/alu_result_stage.sv
//------------------------------------------------------------------------------
// alu_result_stage : registered ALU result select, MULTU shift-add, HI/LO regs
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Signal,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [WIDTH-1:0] alu_data,
    input  logic [WIDTH-1:0] shift_data,
    output logic [WIDTH-1:0] dataOut,
    output logic             result_valid,
    output logic             mult_done,
    output logic             busy
);

    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_srl   = 6'b000010;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rv_q, rv_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       sum;
    logic                 accept;

    assign busy         = (state_q == ST_MUL);
    assign op_ready     = !busy;
    assign accept       = op_valid && op_ready;
    assign dataOut      = dout_q;
    assign result_valid = rv_q;
    assign mult_done    = done_q;

    // One shift-add step; the extra sum bit keeps the carry out of the high half.
    assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        rv_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (Signal)
                        c_fn_add, c_fn_sub, c_fn_and, c_fn_or, c_fn_slt: begin
                            dout_d = alu_data;
                            rv_d   = 1'b1;
                        end
                        c_fn_srl: begin
                            dout_d = shift_data;
                            rv_d   = 1'b1;
                        end
                        c_fn_mfhi: begin
                            dout_d = hi_q;
                            rv_d   = 1'b1;
                        end
                        c_fn_mflo: begin
                            dout_d = lo_q;
                            rv_d   = 1'b1;
                        end
                        c_fn_multu: begin
                            p_d     = {{WIDTH{1'b0}}, dataB};
                            m_d     = dataA;
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end
                        default: begin
                            dout_d = '0;
                            rv_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_last_iter) begin
                    hi_d    = p_d[2*WIDTH-1:WIDTH];
                    lo_d    = p_d[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            done_q  <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
//------------------------------------------------------------------------------
// tb_alu_result_stage : directed self-checking bench for alu_result_stage
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_result_stage;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_BAD   = 6'b111111;

    logic        clk;
    logic        reset;
    logic [5:0]  Signal;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] dataA, dataB, alu_data, shift_data;
    logic [31:0] dataOut;
    logic        result_valid, mult_done, busy;

    int checks   = 0;
    int failures = 0;

    alu_result_stage #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .Signal       (Signal),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .dataA        (dataA),
        .dataB        (dataB),
        .alu_data     (alu_data),
        .shift_data   (shift_data),
        .dataOut      (dataOut),
        .result_valid (result_valid),
        .mult_done    (mult_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted (bounded), then drop op_valid.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alu, input logic [31:0] sh);
        int guard;
        Signal     = sig;
        dataA      = a;
        dataB      = b;
        alu_data   = alu;
        shift_data = sh;
        op_valid   = 1'b1;
        guard      = 0;
        while (!op_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("issue_timeout", 32'(guard), 32'd0);
        tick();
        op_valid = 1'b0;
    endtask

    // Called just after the MULTU accept edge; counts busy cycles up to completion.
    task automatic wait_mult(input string tag, input logic [31:0] dout_exp);
        int cycles;
        int bad_flags;
        cycles    = 0;
        bad_flags = 0;
        while (busy && cycles < 100) begin
            if (op_ready || result_valid || mult_done) bad_flags++;
            cycles++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(cycles), 32'd32);
        check({tag, "_flags_while_busy"}, 32'(bad_flags), 32'd0);
        check({tag, "_mult_done"}, {31'd0, mult_done}, 32'd1);
        check({tag, "_dout_kept"}, dataOut, dout_exp);
        tick();
        check({tag, "_mult_done_pulse"}, {31'd0, mult_done}, 32'd0);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        check({tag, "_data"}, dataOut, exp);
    endtask

    initial begin
        int edges;
        reset      = 1'b0;
        Signal     = '0;
        op_valid   = 1'b0;
        dataA      = '0;
        dataB      = '0;
        alu_data   = '0;
        shift_data = '0;

        #2;
        check("rst_dout", dataOut, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, mult_done}, 32'd0);
        check("rst_ready", {31'd0, op_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Combinational-result ops: one-cycle latency and single-cycle valid.
        issue(FN_ADD, 32'h0, 32'h0, 32'h0000_1234, 32'hDEAD_BEEF);
        expect_result("add", 32'h0000_1234);
        tick();
        check("add_valid_drop", {31'd0, result_valid}, 32'd0);
        check("add_hold", dataOut, 32'h0000_1234);

        issue(FN_SUB, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0);
        expect_result("sub", 32'hFFFF_FFFE);
        issue(FN_SLT, 32'h0, 32'h0, 32'h0000_0001, 32'h0);
        expect_result("slt", 32'h0000_0001);
        issue(FN_SRL, 32'h0, 32'h0, 32'hAAAA_AAAA, 32'h0F00_0000);
        expect_result("srl", 32'h0F00_0000);
        issue(FN_BAD, 32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222);
        expect_result("undef", 32'h0000_0000);
        issue(FN_ADD, 32'h0, 32'h0, 32'h0000_00AB, 32'h0);
        expect_result("add2", 32'h0000_00AB);

        // MULTU max x max, then read back both halves.
        issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 32'h6666_6666);
        check("multu_no_valid", {31'd0, result_valid}, 32'd0);
        check("multu_busy", {31'd0, busy}, 32'd1);
        wait_mult("mul_max", 32'h0000_00AB);
        issue(FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_result("mfhi_max", 32'hFFFF_FFFE);
        issue(FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_result("mflo_max", 32'h0000_0001);

        // 7 x 6 overwrites HI/LO.
        issue(FN_MULTU, 32'd7, 32'd6, 32'h0, 32'h0);
        wait_mult("mul_7x6", 32'h0000_0001);
        issue(FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_result("mfhi_42", 32'h0);
        issue(FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_result("mflo_42", 32'd42);

        // MFLO arriving mid-multiply stalls and reads the final LO at E33.
        issue(FN_MULTU, 32'd3, 32'd5, 32'h0, 32'h0);
        edges = 0;
        repeat (4) begin
            tick();
            edges++;
        end
        Signal   = FN_MFLO;
        op_valid = 1'b1;
        check("stall_ready_low", {31'd0, op_ready}, 32'd0);
        while (!op_ready && edges < 100) begin
            if (result_valid) check("stall_early_valid", 32'd1, 32'd0);
            tick();
            edges++;
        end
        check("stall_release_edge", 32'(edges), 32'd32);
        tick();
        op_valid = 1'b0;
        expect_result("stall_mflo", 32'd15);

        // Async reset mid-multiply aborts and clears HI/LO.
        issue(FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0);
        repeat (9) tick();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, op_ready}, 32'd1);
        check("abort_dout", dataOut, 32'd0);
        tick();
        reset = 1'b1;
        issue(FN_ADD, 32'h0, 32'h0, 32'h0BAD_CAFE, 32'h0);
        expect_result("post_rst_add", 32'h0BAD_CAFE);
        issue(FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_result("post_rst_hi", 32'h0);
        issue(FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_result("post_rst_lo", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
